draw_sprite: RTL and testbench



---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_if.sv | 18 +
 rtl/delay.sv | 31 +++
 rtl/draw_sprite.sv | 159 +++++++++++++++
 tb/tb_draw_sprite.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen size, default transparent colour key,
// sprite dimensions for the cat and dog bitmaps, and the packed timing
// record carried alongside pixel data through pipelined draw stages.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    localparam logic [11:0] KEY_COLOR_DEFAULT = 12'hF0F;

    localparam int CAT_W = 64;
    localparam int CAT_H = 64;
    localparam int DOG_W = 64;
    localparam int DOG_H = 64;

    typedef enum logic {
        SPRITE_CAT,
        SPRITE_DOG
    } sprite_kind_e;

    // Everything about a pixel except its colour; delayed as one bundle.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle shared by every stage of the drawing chain.
// 'out'/'master' is the driving side, 'in'/'slave' the receiving side.
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/delay.sv
// Fixed-length register chain used to keep side-band data aligned with a
// pipeline. DEPTH must be at least 1; every stage clears on reset.
module delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the input one stage further down the chain every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage for the VGA chain. Overlays a SPRITE_W x SPRITE_H
// bitmap fetched from an external synchronous ROM at a position latched once
// per frame, with a fixed three-clock latency on every output field.
// Optional build macro: DRAW_SPRITE_TRANSP_EN enables colour-keyed
// transparency (ROM pixels equal to KEY_COLOR show the background).
module draw_sprite
    import vga_pkg::*;
#(
    parameter int          SPRITE_W  = CAT_W,
    parameter int          SPRITE_H  = CAT_H,
    parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEFAULT,
    localparam int         ADDR_W    = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_if.in                 vga_in,
    vga_if.out                vga_out,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic [11:0]       rgb_pixel
);

    localparam int          W_BITS = $clog2(SPRITE_W);
    localparam int          H_BITS = $clog2(SPRITE_H);
    localparam logic [11:0] W_EXT  = 12'(SPRITE_W);
    localparam logic [11:0] H_EXT  = 12'(SPRITE_H);

`ifdef DRAW_SPRITE_TRANSP_EN
    localparam logic TRANSP_EN = 1'b1;
`else
    localparam logic TRANSP_EN = 1'b0;
`endif

    logic              r_vblnkPrev;
    logic [10:0]       r_xposL;
    logic [10:0]       r_yposL;
    logic              r_inBox1;
    logic              r_inBox2;
    logic [ADDR_W-1:0] r_pixelAddr;
    logic [11:0]       r_rgbOut;

    logic              w_vblnkRise;
    logic [11:0]       w_hExt;
    logic [11:0]       w_vExt;
    logic [11:0]       w_xExt;
    logic [11:0]       w_yExt;
    logic              w_inBox;
    logic [W_BITS-1:0] w_dx;
    logic [H_BITS-1:0] w_dy;
    logic [11:0]       w_bg2;
    logic              w_keyHit;
    logic              w_useSprite;
    vga_timing_t       w_timingIn;
    vga_timing_t       w_timingOut;

    assign w_vblnkRise = vga_in.vblnk & ~r_vblnkPrev;

    // Capture the sprite position only at the start of vertical blanking so
    // a frame is never drawn with two different positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnkPrev <= 1'b0;
            r_xposL     <= '0;
            r_yposL     <= '0;
        end else begin
            r_vblnkPrev <= vga_in.vblnk;
            if (w_vblnkRise) begin
                r_xposL <= xpos;
                r_yposL <= ypos;
            end
        end
    end

    // Box test in 12 bits so position + size cannot wrap; anything past the
    // screen edge is simply never reached by hcount/vcount.
    assign w_hExt  = {1'b0, vga_in.hcount};
    assign w_vExt  = {1'b0, vga_in.vcount};
    assign w_xExt  = {1'b0, r_xposL};
    assign w_yExt  = {1'b0, r_yposL};
    assign w_inBox = !vga_in.hblnk && !vga_in.vblnk
                   && (w_hExt >= w_xExt) && (w_hExt < w_xExt + W_EXT)
                   && (w_vExt >= w_yExt) && (w_vExt < w_yExt + H_EXT);

    // Only the low bits of the offsets are needed; they equal the low bits
    // of the full differences because the sizes are powers of two.
    assign w_dx = vga_in.hcount[W_BITS-1:0] - r_xposL[W_BITS-1:0];
    assign w_dy = vga_in.vcount[H_BITS-1:0] - r_yposL[H_BITS-1:0];

    // Stage 1 registers the box flag and the ROM address (zero outside).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inBox1    <= 1'b0;
            r_pixelAddr <= '0;
        end else begin
            r_inBox1    <= w_inBox;
            r_pixelAddr <= w_inBox ? {w_dy, w_dx} : '0;
        end
    end

    assign pixel_addr = r_pixelAddr;

    // Stage 2 holds the box flag while the ROM produces the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inBox2 <= 1'b0;
        end else begin
            r_inBox2 <= r_inBox1;
        end
    end

    assign w_timingIn.hcount = vga_in.hcount;
    assign w_timingIn.vcount = vga_in.vcount;
    assign w_timingIn.hsync  = vga_in.hsync;
    assign w_timingIn.vsync  = vga_in.vsync;
    assign w_timingIn.hblnk  = vga_in.hblnk;
    assign w_timingIn.vblnk  = vga_in.vblnk;

    delay #(
        .WIDTH ($bits(vga_timing_t)),
        .DEPTH (3)
    ) u_timingDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_timingIn),
        .o_data (w_timingOut)
    );

    delay #(
        .WIDTH (12),
        .DEPTH (2)
    ) u_bgDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (vga_in.rgb),
        .o_data (w_bg2)
    );

    assign w_keyHit    = (rgb_pixel == KEY_COLOR);
    assign w_useSprite = r_inBox2 && !(TRANSP_EN && w_keyHit);

    // Stage 3 picks sprite or background colour into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgbOut <= '0;
        end else begin
            r_rgbOut <= w_useSprite ? rgb_pixel : w_bg2;
        end
    end

    assign vga_out.hcount = w_timingOut.hcount;
    assign vga_out.vcount = w_timingOut.vcount;
    assign vga_out.hsync  = w_timingOut.hsync;
    assign vga_out.vsync  = w_timingOut.vsync;
    assign vga_out.hblnk  = w_timingOut.hblnk;
    assign vga_out.vblnk  = w_timingOut.vblnk;
    assign vga_out.rgb    = r_rgbOut;

endmodule

// File: tb/tb_draw_sprite.sv
// Testbench for draw_sprite: drives a VGA pixel stream (not necessarily in
// raster order), models a synchronous ROM that returns its own address, and
// predicts every output from the overlay rules with plain arithmetic.
module tb_draw_sprite;
    import vga_pkg::*;

    localparam int          SPRITE_W = 64;
    localparam int          SPRITE_H = 64;
    localparam int          ADDR_W   = 12;
    localparam logic [11:0] KEY      = 12'hF0F;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [10:0]       xpos      = '0;
    logic [10:0]       ypos      = '0;
    logic [ADDR_W-1:0] pixel_addr;
    logic [11:0]       rgb_pixel = '0;

    vga_if vgaIn ();
    vga_if vgaOut ();

    pix_t        expQ[$];
    logic [11:0] addrQ[$];
    int          checks      = 0;
    int          failures    = 0;
    int          modelX      = 0;
    int          modelY      = 0;
    bit          modelPrevVb = 1'b0;

    draw_sprite #(
        .SPRITE_W  (SPRITE_W),
        .SPRITE_H  (SPRITE_H),
        .KEY_COLOR (KEY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_in     (vgaIn),
        .vga_out    (vgaOut),
        .xpos       (xpos),
        .ypos       (ypos),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel)
    );

    // Pixel clock.
    always #5 clk = ~clk;

    // Synchronous image ROM whose content at each address is the address.
    always @(posedge clk) rgb_pixel <= pixel_addr;

    function automatic pix_t observed();
        return {vgaOut.hcount, vgaOut.vcount, vgaOut.hsync, vgaOut.vsync,
                vgaOut.hblnk, vgaOut.vblnk, vgaOut.rgb};
    endfunction

    task automatic modelReset();
        expQ.delete();
        addrQ.delete();
        repeat (3) begin
            expQ.push_back('0);
            addrQ.push_back('0);
        end
        modelX      = 0;
        modelY      = 0;
        modelPrevVb = 1'b0;
    endtask

    task automatic checkResetZero(input string tag);
        pix_t act;
        act = observed();
        checks++;
        assert (act === '0) else begin
            failures++;
            $error("[TB] FAIL %s vga_out observed=%h expected=0", tag, act);
        end
        checks++;
        assert (pixel_addr === '0) else begin
            failures++;
            $error("[TB] FAIL %s pixel_addr observed=%h expected=0", tag, pixel_addr);
        end
    endtask

    task automatic checkOutput();
        pix_t        act;
        pix_t        expPix;
        logic [11:0] expAddr;
        expPix  = expQ[expQ.size()-4];
        expAddr = addrQ[addrQ.size()-2];
        act     = observed();
        checks++;
        assert (act === expPix) else begin
            failures++;
            $error("[TB] FAIL vga_out observed h=%0d v=%0d s=%b%b b=%b%b rgb=%h expected h=%0d v=%0d s=%b%b b=%b%b rgb=%h",
                   act.hcount, act.vcount, act.hsync, act.vsync, act.hblnk, act.vblnk, act.rgb,
                   expPix.hcount, expPix.vcount, expPix.hsync, expPix.vsync, expPix.hblnk,
                   expPix.vblnk, expPix.rgb);
        end
        checks++;
        assert (pixel_addr === expAddr) else begin
            failures++;
            $error("[TB] FAIL pixel_addr observed=%h expected=%h", pixel_addr, expAddr);
        end
        while (expQ.size() > 4) void'(expQ.pop_front());
        while (addrQ.size() > 4) void'(addrQ.pop_front());
    endtask

    // Called at posedge+1; drives one pixel, predicts its result, checks
    // the outputs at the following negedge and returns at the next posedge+1.
    task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                                 input logic hb, input logic vb, input logic [11:0] bg);
        pix_t        p;
        pix_t        e;
        int          hi;
        int          vi;
        int          dx;
        int          dy;
        int          addr;
        bit          inBox;
        bit          useSprite;
        logic [11:0] romVal;
        p.hcount = h;
        p.vcount = v;
        p.hsync  = 1'($urandom);
        p.vsync  = 1'($urandom);
        p.hblnk  = hb;
        p.vblnk  = vb;
        p.rgb    = (hb || vb) ? 12'h000 : bg;
        vgaIn.hcount = p.hcount;
        vgaIn.vcount = p.vcount;
        vgaIn.hsync  = p.hsync;
        vgaIn.vsync  = p.vsync;
        vgaIn.hblnk  = p.hblnk;
        vgaIn.vblnk  = p.vblnk;
        vgaIn.rgb    = p.rgb;
        hi    = h;
        vi    = v;
        dx    = hi - modelX;
        dy    = vi - modelY;
        inBox = !hb && !vb && dx >= 0 && dx < SPRITE_W && dy >= 0 && dy < SPRITE_H;
        addr  = inBox ? dy * SPRITE_W + dx : 0;
        romVal    = 12'(addr);
        useSprite = inBox;
`ifdef DRAW_SPRITE_TRANSP_EN
        if (romVal == KEY) useSprite = 1'b0;
`endif
        e = p;
        if (useSprite) e.rgb = romVal;
        expQ.push_back(e);
        addrQ.push_back(12'(addr));
        if (vb && !modelPrevVb) begin
            modelX = xpos;
            modelY = ypos;
        end
        modelPrevVb = vb;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic drawSpan(input int v, input int hFrom, input int hTo);
        for (int h = hFrom; h <= hTo; h++) begin
            applyStimulus(11'(h), 11'(v), h >= HOR_PIXELS, v >= VER_PIXELS, 12'($urandom));
        end
    endtask

    task automatic frameStart();
        applyStimulus(11'd0, 11'(VER_PIXELS), 1'b1, 1'b1, 12'h000);
        applyStimulus(11'd1, 11'(VER_PIXELS), 1'b1, 1'b1, 12'h000);
        applyStimulus(11'd2, 11'(VER_PIXELS + 1), 1'b1, 1'b1, 12'h000);
    endtask

    task automatic resetPulse();
        #1 rst_n = 1'b0;
        #1 checkResetZero("midReset");
        repeat (5) begin
            @(posedge clk);
            #1 checkResetZero("midResetHold");
        end
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        int xp;
        int yp;
        int vv;
        int hs;
        vgaIn.hcount = '0;
        vgaIn.vcount = '0;
        vgaIn.hsync  = 1'b0;
        vgaIn.vsync  = 1'b0;
        vgaIn.hblnk  = 1'b0;
        vgaIn.vblnk  = 1'b0;
        vgaIn.rgb    = '0;

        // Reset held while the stream already runs.
        @(posedge clk);
        #1 vgaIn.hcount = 11'd37;
        vgaIn.rgb = 12'hABC;
        #1 checkResetZero("reset");
        repeat (2) begin
            @(posedge clk);
            #2 checkResetZero("resetHold");
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        modelReset();

        // Sprite at (0,0) until the first vblnk rise.
        drawSpan(5, 0, 70);

        // Sprite at (100,200): corners, edges and the key-colour pixel.
        xpos = 11'd100;
        ypos = 11'd200;
        frameStart();
        drawSpan(200, 95, 170);
        drawSpan(263, 155, 170);
        drawSpan(264, 95, 110);
        applyStimulus(11'd115, 11'd260, 1'b0, 1'b0, 12'h123);

        // Position change mid-frame only shows up after the next vblnk rise.
        drawSpan(400, 95, 110);
        xpos = 11'd300;
        drawSpan(250, 95, 170);
        frameStart();
        drawSpan(250, 290, 370);

        // Sprite crossing the right edge is clipped, never wrapped.
        xpos = 11'd780;
        ypos = 11'd10;
        frameStart();
        drawSpan(20, 770, 805);
        drawSpan(21, 0, 50);

        // Random positions with spans around the box and stray xpos writes.
        for (int f = 0; f < 6; f++) begin
            xpos = 11'($urandom_range(0, 799));
            ypos = 11'($urandom_range(0, 599));
            frameStart();
            xp = xpos;
            yp = ypos;
            for (int l = 0; l < 3; l++) begin
                vv = yp + int'($urandom_range(0, 70)) - 3;
                if (vv < 0) vv = 0;
                hs = xp - 4;
                if (hs < 0) hs = 0;
                drawSpan(vv, hs, xp + 70);
                xpos = 11'($urandom_range(0, 799));
            end
        end

        // Reset in the middle of a frame drops the position back to (0,0).
        xpos = 11'd50;
        ypos = 11'd40;
        frameStart();
        drawSpan(300, 0, 20);
        resetPulse();
        drawSpan(10, 0, 70);
        drawSpan(63, 60, 66);
        frameStart();
        drawSpan(45, 40, 120);

        // Flush the pipeline with blanking pixels.
        drawSpan(VER_PIXELS + 1, 800, 805);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
